// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement scheduler: picks the next enabled RO in round-robin order,
// lets it settle, counts its edges over a tick-based gate window and hands the result off.
module ro_meas_ctrl #(
  parameter int NUM_RO       = 4,
  parameter int CNT_W        = 16,
  parameter int SETTLE_TICKS = 2,
  parameter int GATE_TICKS   = 8,
  localparam int IDW         = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NUM_RO-1:0] ro_mask,
  input  logic              tick,
  input  logic [NUM_RO-1:0] ro_edge,
  output logic [NUM_RO-1:0] ro_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf,
  output logic              busy
);

  localparam int TMAX = (SETTLE_TICKS > GATE_TICKS) ? SETTLE_TICKS : GATE_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]     SETTLE_LAST = TW'((SETTLE_TICKS > 0) ? SETTLE_TICKS - 1 : 0);
  localparam logic [TW-1:0]     GATE_LAST   = TW'(GATE_TICKS - 1);
  localparam logic [IDW-1:0]    LAST_ID     = IDW'(NUM_RO - 1);
  localparam logic [IDW:0]      NUM_RO_W    = (IDW + 1)'(NUM_RO);
  localparam logic [NUM_RO-1:0] ONE_HOT0    = NUM_RO'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   sel;
  logic [TW-1:0]    tick_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             edge_ovf;

  // Saturating edge increment; the top bit of the result is the sticky overflow flag.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic ovf);
    if (&cnt) return {1'b1, cnt};
    else      return {ovf, cnt + 1'b1};
  endfunction

  // Round-robin pick: rotate the mask so bit 0 lines up with ptr, take the lowest set bit.
  logic [2*NUM_RO-1:0] mask_dbl;
  logic [NUM_RO-1:0]   mask_rot;
  logic [IDW:0]        pick_sum;
  logic [IDW-1:0]      pick;

  always_comb begin
    mask_dbl = {ro_mask, ro_mask};
    mask_rot = NUM_RO'(mask_dbl >> ptr);
    pick_sum = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (mask_rot[i]) pick_sum = {1'b0, ptr} + (IDW + 1)'(i);
    end
    if (pick_sum >= NUM_RO_W) pick_sum = pick_sum - NUM_RO_W;
    pick = pick_sum[IDW-1:0];
  end

  logic           edge_sel;
  logic           settle_done;
  logic           gate_done;
  logic [CNT_W:0] gate_next;
  logic [IDW-1:0] next_ptr;

  assign edge_sel    = ro_edge[sel];
  assign settle_done = (SETTLE_TICKS == 0) || (tick && (tick_cnt == SETTLE_LAST));
  assign gate_done   = tick && (tick_cnt == GATE_LAST);
  assign gate_next   = edge_sel ? sat_inc(edge_cnt, edge_ovf) : {edge_ovf, edge_cnt};
  assign next_ptr    = (sel == LAST_ID) ? '0 : sel + 1'b1;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      tick_cnt  <= '0;
      edge_cnt  <= '0;
      edge_ovf  <= 1'b0;
      ro_en     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run && (|ro_mask)) begin
            sel      <= pick;
            ro_en    <= ONE_HOT0 << pick;
            tick_cnt <= '0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!run) begin
            ro_en    <= '0;
            tick_cnt <= '0;
            state    <= IDLE;
          end else if (settle_done) begin
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
            tick_cnt <= '0;
            state    <= GATE;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        GATE: begin
          if (!run) begin
            ro_en    <= '0;
            tick_cnt <= '0;
            state    <= IDLE;
          end else begin
            {edge_ovf, edge_cnt} <= gate_next;
            // The edge arriving with the last gate tick is part of the result.
            if (gate_done) begin
              res_count <= gate_next[CNT_W-1:0];
              res_ovf   <= gate_next[CNT_W];
              res_id    <= sel;
              res_valid <= 1'b1;
              ro_en     <= '0;
              tick_cnt  <= '0;
              state     <= DONE;
            end else if (tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_en_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ro_en));
  a_res_hold  : assert property (@(posedge clk) disable iff (rst)
                  (res_valid && !res_ready) |=> (res_valid && $stable({res_id, res_count, res_ovf})));

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Bench for ro_meas_ctrl: directed measurement table, hand-written corner sequences and a
// randomized run compared against a window-based reference model.
module tb_ro_meas_ctrl;
  localparam int NR     = 1500;
  localparam int SETTLE = 2;
  localparam int GATE   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, run2, tick, res_ready;
  logic [3:0]  ro_mask, ro_edge;
  logic [3:0]  ro_en, ro_en2;
  logic        res_valid, res_valid2, res_ovf, res_ovf2, busy, busy2;
  logic [1:0]  res_id, res_id2;
  logic [15:0] res_count;
  logic [3:0]  res_count2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ro_meas_ctrl #(.NUM_RO(4), .CNT_W(16), .SETTLE_TICKS(SETTLE), .GATE_TICKS(GATE)) dut (
    .clk(clk), .rst(rst), .run(run), .ro_mask(ro_mask), .tick(tick), .ro_edge(ro_edge),
    .ro_en(ro_en), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_count(res_count), .res_ovf(res_ovf), .busy(busy)
  );

  ro_meas_ctrl #(.NUM_RO(4), .CNT_W(4), .SETTLE_TICKS(SETTLE), .GATE_TICKS(GATE)) dut_ovf (
    .clk(clk), .rst(rst), .run(run2), .ro_mask(ro_mask), .tick(tick), .ro_edge(ro_edge),
    .ro_en(ro_en2), .res_valid(res_valid2), .res_ready(res_ready), .res_id(res_id2),
    .res_count(res_count2), .res_ovf(res_ovf2), .busy(busy2)
  );

  typedef struct {
    int          p;
    int          e;
    logic [3:0]  bits;
    logic [3:0]  mask;
    logic [1:0]  id;
    logic [15:0] cnt;
  } row_t;

  row_t rows[6];
  int   rr_exp[4] = '{1, 3, 1, 3};
  int   ids[$];

  logic [3:0]  r_mask[NR];
  logic [3:0]  r_edge[NR];
  logic        r_tick[NR];
  logic        r_ready[NR];
  logic [24:0] exp_obs[NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with a periodic tick (period p) and edges on 'bits' every e cycles.
  task automatic step(input int p, input int e, input logic [3:0] bits);
    tick    = ((cyc % p) == 0);
    ro_edge = ((cyc % e) == 0) ? bits : 4'b0000;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic measure(input int p, input int e, input logic [3:0] bits, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      step(p, e, bits);
      if (res_valid) ok = 1'b1;
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    run       = 1'b0;
    step(1, 1, 4'b0000);
    res_ready = 1'b0;
    check("accept_clears", {res_valid, busy, ro_en}, 6'b0);
  endtask

  function automatic int kth_tick(input int after, input int k);
    int seen;
    seen = 0;
    for (int m = after + 1; m < NR; m++) begin
      if (r_tick[m]) begin
        seen++;
        if (seen == k) return m;
      end
    end
    return NR;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ok;
    int         bad, quiet;
    int         s, e, g, c, n, ptr_m, sel_m, cnt;
    logic [3:0] mk, ed;
    logic [24:0] obs;

    rows[0] = '{10, 2, 4'b1111, 4'b0001, 2'd0, 16'd40};
    rows[1] = '{4,  1, 4'b1111, 4'b0100, 2'd2, 16'd32};
    rows[2] = '{5,  4, 4'b1111, 4'b1001, 2'd3, 16'd10};
    rows[3] = '{1,  1, 4'b1111, 4'b1111, 2'd0, 16'd8};
    rows[4] = '{7,  7, 4'b1111, 4'b0010, 2'd1, 16'd8};
    rows[5] = '{3,  1, 4'b1110, 4'b0011, 2'd0, 16'd0};

    rst = 1'b1; run = 1'b0; run2 = 1'b0; tick = 1'b0; res_ready = 1'b0;
    ro_mask = 4'b0000; ro_edge = 4'b0000;
    step(1, 1, 4'b0000);
    step(1, 1, 4'b0000);
    check("reset_state", {ro_en, busy, res_valid, res_id, res_count, res_ovf}, 25'b0);
    rst = 1'b0;
    ro_mask = 4'b1111;
    step(1, 1, 4'b1111);
    check("idle_without_run", {ro_en, busy, res_valid}, 6'b0);

    for (int r = 0; r < 6; r++) begin
      ro_mask = rows[r].mask; run = 1'b1; res_ready = 1'b0;
      measure(rows[r].p, rows[r].e, rows[r].bits, ok);
      check($sformatf("row%0d_done", r), ok, 1'b1);
      check($sformatf("row%0d_result", r), {res_id, res_count, res_ovf},
            {rows[r].id, rows[r].cnt, 1'b0});
      accept();
    end

    // Overflow on the narrow-counter instance.
    ro_mask = 4'b0001; run2 = 1'b1; ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      step(2, 1, 4'b1111);
      if (res_valid2) ok = 1'b1;
    end
    check("ovf_done", ok, 1'b1);
    check("ovf_result", {res_id2, res_count2, res_ovf2}, {2'd0, 4'hF, 1'b1});
    res_ready = 1'b1; run2 = 1'b0;
    step(1, 1, 4'b0000);
    res_ready = 1'b0;
    check("ovf_accept", {res_valid2, busy2}, 2'b00);

    // Backpressure: result must hold while the consumer stalls.
    ro_mask = 4'b0010; run = 1'b1; res_ready = 1'b0;
    measure(4, 2, 4'b1111, ok);
    check("bp_done", ok, 1'b1);
    check("bp_result", {res_id, res_count, res_ovf}, {2'd1, 16'd16, 1'b0});
    ro_mask = 4'b1111;
    for (int k = 0; k < 50; k++) begin
      step(4, 2, 4'b1111);
      check("bp_hold", {ro_en, busy, res_valid, res_id, res_count, res_ovf},
            {4'b0000, 1'b1, 1'b1, 2'd1, 16'd16, 1'b0});
    end
    accept();

    // Abort mid-gate, then re-raise run: the same RO must be chosen again.
    ro_mask = 4'b0100; run = 1'b1; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step(4, 1, 4'b1111);
      if (ro_en != 4'b0000) ok = 1'b1;
    end
    check("abort_select", ok, 1'b1);
    for (int k = 0; k < 12; k++) step(4, 1, 4'b1111);
    check("abort_pre", {ro_en, busy}, {4'b0100, 1'b1});
    run = 1'b0;
    step(4, 1, 4'b1111);
    check("abort_now", {ro_en, busy, res_valid}, 6'b0);
    quiet = 0;
    for (int k = 0; k < 5; k++) begin
      step(4, 1, 4'b1111);
      if (res_valid || busy) quiet++;
    end
    check("abort_quiet", quiet, 0);
    ro_mask = 4'b0110; run = 1'b1;
    step(4, 1, 4'b1111);
    check("abort_reselect", ro_en, 4'b0100);
    measure(4, 1, 4'b1111, ok);
    check("abort_redo_result", {ok, res_id, res_count, res_ovf}, {1'b1, 2'd2, 16'd32, 1'b0});
    accept();

    // Asynchronous reset mid-gate, then round robin from a cleared pointer.
    ro_mask = 4'b1010; run = 1'b1; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step(4, 1, 4'b1111);
      if (ro_en != 4'b0000) ok = 1'b1;
    end
    check("rst_select", ro_en, 4'b1000);
    for (int k = 0; k < 12; k++) step(4, 1, 4'b1111);
    #2 rst = 1'b1;
    #1 check("rst_async", {ro_en, busy, res_valid}, 6'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    res_ready = 1'b1;
    bad = 0;
    ids.delete();
    for (int k = 0; k < 400 && ids.size() < 4; k++) begin
      step(1, 1, 4'b1111);
      if (ro_en != 4'b0000 && ro_en != 4'b0010 && ro_en != 4'b1000) bad++;
      if (res_valid) ids.push_back(int'(res_id));
    end
    check("rr_count", ids.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_id%0d", k), (k < ids.size()) ? ids[k] : 99, rr_exp[k]);
    check("rr_en_legal", bad, 0);

    // Randomized run against the window model.
    rst = 1'b1; run = 1'b0; res_ready = 1'b0;
    step(1, 1, 4'b0000);
    rst = 1'b0;
    step(1, 1, 4'b0000);
    for (int m = 0; m < NR; m++) begin
      r_tick[m]  = ($urandom_range(0, 2) == 0);
      r_edge[m]  = 4'($urandom);
      r_ready[m] = 1'($urandom_range(0, 1));
      r_mask[m]  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      exp_obs[m] = '0;
    end
    ptr_m = 0;
    n = 0;
    while (n < NR) begin
      if (r_mask[n] == 4'b0000) begin
        n++;
      end else begin
        s = n;
        mk = r_mask[s];
        sel_m = -1;
        for (int k = 0; k < 4; k++)
          if (sel_m < 0 && mk[2'((ptr_m + k) % 4)]) sel_m = (ptr_m + k) % 4;
        e = kth_tick(s, SETTLE);
        g = (e >= NR) ? NR : kth_tick(e, GATE);
        cnt = 0;
        for (int m = e + 1; m <= g && m < NR; m++) begin
          ed = r_edge[m];
          if (ed[2'(sel_m)]) cnt++;
        end
        c = g + 1;
        while (c < NR && !r_ready[c]) c++;
        for (int m = s; m < NR && m < c; m++) begin
          exp_obs[m][20] = 1'b1;
          if (m < g) exp_obs[m][24:21] = 4'(1 << sel_m);
          if (m >= g) exp_obs[m][19:0] = {1'b1, 2'(sel_m), 16'(cnt), 1'b0};
        end
        ptr_m = (sel_m + 1) % 4;
        n = c + 1;
      end
    end
    for (int m = 0; m < NR; m++) begin
      run = 1'b1; ro_mask = r_mask[m]; tick = r_tick[m];
      ro_edge = r_edge[m]; res_ready = r_ready[m];
      @(posedge clk);
      #1;
      obs = {ro_en, busy, res_valid, res_valid ? {res_id, res_count, res_ovf} : 19'b0};
      check($sformatf("random_c%0d", m), obs, exp_obs[m]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
